// File: rtl/s64x7_bus_pkg.sv
// rtl/s64x7_bus_pkg.sv - shared types and widths for the S64X7 bus arbiter
package s64x7_bus_pkg;

  localparam int ADR_W       = 61;
  localparam int SEL_W       = 8;
  localparam int DAT_W       = 64;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/s64x7_bus_arbiter_if.sv
// rtl/s64x7_bus_arbiter_if.sv - two-master/one-slave S64X7 bus bundle
interface s64x7_bus_arbiter_if;
  import s64x7_bus_pkg::*;

  logic [ADR_W-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic             m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i;
  logic             m1_cyc_i, m1_stb_i, m1_we_i, m1_vpa_i;
  logic [SEL_W-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [DAT_W-1:0] m0_dat_i, m1_dat_i, s_dat_o, s_dat_i, dat_o;
  logic             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic             s_cyc_o, s_stb_o, s_we_o, s_vpa_o, s_ack_i;
  logic [1:0]       gnt_o;

  // Requester/slave-model side.
  modport master (
    output m0_adr_i, m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i, m0_sel_i, m0_dat_i,
    output m1_adr_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_vpa_i, m1_sel_i, m1_dat_i,
    output s_ack_i, s_dat_i,
    input  m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_cyc_o, s_stb_o, s_we_o, s_vpa_o, s_sel_o, s_dat_o,
    input  dat_o, gnt_o
  );

  // Arbiter side.
  modport slave (
    input  m0_adr_i, m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i, m0_sel_i, m0_dat_i,
    input  m1_adr_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_vpa_i, m1_sel_i, m1_dat_i,
    input  s_ack_i, s_dat_i,
    output m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_cyc_o, s_stb_o, s_we_o, s_vpa_o, s_sel_o, s_dat_o,
    output dat_o, gnt_o
  );

endinterface

// File: rtl/s64x7_bus_watchdog.sv
// rtl/s64x7_bus_watchdog.sv - hung-transfer timer with one-cycle error pulse
module s64x7_bus_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active_i,
  input  logic cyc_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic err_o,
  output logic suppress_o
);

  logic [CW-1:0] cnt;
  logic          stb_eff;

  assign stb_eff = stb_i & ~suppress_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt        <= '0;
      err_o      <= 1'b0;
      suppress_o <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (!active_i || !cyc_i) begin
        cnt        <= '0;
        suppress_o <= 1'b0;
      end else begin
        // Suppression lasts until the owner withdraws stb of the hung transfer.
        if (!stb_i)
          suppress_o <= 1'b0;
        if (ack_i || !stb_eff)
          cnt <= '0;
        else if (cnt == CW'(TIMEOUT - 1)) begin
          cnt        <= '0;
          err_o      <= 1'b1;
          suppress_o <= 1'b1;
        end else
          cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/s64x7_bus_arbiter.sv
// rtl/s64x7_bus_arbiter.sv - round-robin, burst-locked two-master S64X7 arbiter
import s64x7_bus_pkg::*;

module s64x7_bus_arbiter #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  s64x7_bus_arbiter_if.slave   bus
);

  arb_state_t       state;
  logic             prio;
  logic [ADR_W-1:0] g_adr;
  logic [SEL_W-1:0] g_sel;
  logic [DAT_W-1:0] g_dat;
  logic             g_cyc, g_stb, g_we, g_vpa;
  logic             wd_err, wd_sup;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.m0_cyc_i && bus.m1_cyc_i)
            state <= prio ? ST_G1 : ST_G0;
          else if (bus.m0_cyc_i)
            state <= ST_G0;
          else if (bus.m1_cyc_i)
            state <= ST_G1;
        end
        // Release always passes through IDLE so owners are separated by a cycle.
        ST_G0: if (!bus.m0_cyc_i) begin
          state <= ST_IDLE;
          prio  <= 1'b1;
        end
        ST_G1: if (!bus.m1_cyc_i) begin
          state <= ST_IDLE;
          prio  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    g_adr = '0; g_sel = '0; g_dat = '0;
    g_cyc = 1'b0; g_stb = 1'b0; g_we = 1'b0; g_vpa = 1'b0;
    case (state)
      ST_G0: begin
        g_adr = bus.m0_adr_i; g_sel = bus.m0_sel_i; g_dat = bus.m0_dat_i;
        g_cyc = bus.m0_cyc_i; g_stb = bus.m0_stb_i; g_we = bus.m0_we_i; g_vpa = bus.m0_vpa_i;
      end
      ST_G1: begin
        g_adr = bus.m1_adr_i; g_sel = bus.m1_sel_i; g_dat = bus.m1_dat_i;
        g_cyc = bus.m1_cyc_i; g_stb = bus.m1_stb_i; g_we = bus.m1_we_i; g_vpa = bus.m1_vpa_i;
      end
      default: ;
    endcase
  end

  s64x7_bus_watchdog #(.TIMEOUT(TIMEOUT), .CW(CW)) u_wd (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .active_i   (state != ST_IDLE),
    .cyc_i      (g_cyc),
    .stb_i      (g_stb),
    .ack_i      (bus.s_ack_i),
    .err_o      (wd_err),
    .suppress_o (wd_sup)
  );

  assign bus.s_adr_o  = g_adr;
  assign bus.s_sel_o  = g_sel;
  assign bus.s_dat_o  = g_dat;
  assign bus.s_cyc_o  = g_cyc;
  assign bus.s_stb_o  = g_stb & ~wd_sup;
  assign bus.s_we_o   = g_we;
  assign bus.s_vpa_o  = g_vpa;
  assign bus.dat_o    = bus.s_dat_i;
  assign bus.gnt_o    = {state == ST_G1, state == ST_G0};
  assign bus.m0_ack_o = (state == ST_G0) & bus.s_ack_i & bus.m0_stb_i;
  assign bus.m1_ack_o = (state == ST_G1) & bus.s_ack_i & bus.m1_stb_i;
  assign bus.m0_err_o = (state == ST_G0) & wd_err;
  assign bus.m1_err_o = (state == ST_G1) & wd_err;

endmodule

// File: tb/tb_s64x7_bus_arbiter.sv
// tb/tb_s64x7_bus_arbiter.sv - directed self-checking bench for s64x7_bus_arbiter
module tb_s64x7_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  s64x7_bus_arbiter_if bus ();

  s64x7_bus_arbiter #(.TIMEOUT(16), .CW(8)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] alt_exp [5];

  initial begin
    alt_exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    rst = 1'b1;
    bus.m0_adr_i = 61'h1C00_0000_0000_0000; bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    bus.m0_we_i = 1'b0; bus.m0_vpa_i = 1'b1; bus.m0_sel_i = 8'hFF; bus.m0_dat_i = '0;
    bus.m1_adr_i = 61'h20; bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b0;
    bus.m1_we_i = 1'b0; bus.m1_vpa_i = 1'b0; bus.m1_sel_i = 8'h0F; bus.m1_dat_i = 64'h5A;
    bus.s_ack_i = 1'b0; bus.s_dat_i = 64'hDEAD_BEEF_0000_1234;

    #3;
    check("rst_gnt", 64'(bus.gnt_o), 64'h0);
    check("rst_cyc", 64'(bus.s_cyc_o), 64'h0);
    check("rst_adr", 64'(bus.s_adr_o), 64'h0);
    step(); step();
    check("rst_hold_gnt", 64'(bus.gnt_o), 64'h0);
    rst = 1'b0;
    #1;
    check("latency_gnt", 64'(bus.gnt_o), 64'h0);
    step();
    check("post_rst_gnt", 64'(bus.gnt_o), 64'h1);
    check("post_rst_adr", 64'(bus.s_adr_o), 64'h1C00_0000_0000_0000);
    check("post_rst_vpa", 64'(bus.s_vpa_o), 64'h1);
    check("post_rst_sel", 64'(bus.s_sel_o), 64'hFF);
    check("dat_bcast", bus.dat_o, 64'hDEAD_BEEF_0000_1234);
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_vpa_i = 1'b0; bus.m1_cyc_i = 1'b0;
    step();
    check("release_gnt", 64'(bus.gnt_o), 64'h0);

    // Core single write
    bus.m0_adr_i = 61'h1111_1110; bus.m0_we_i = 1'b1; bus.m0_dat_i = 64'h41;
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    #1;
    check("wr_latency_cyc", 64'(bus.s_cyc_o), 64'h0);
    step();
    check("wr_dat", bus.s_dat_o, 64'h41);
    check("wr_adr", 64'(bus.s_adr_o), 64'h1111_1110);
    check("wr_we", 64'(bus.s_we_o), 64'h1);
    check("wr_noack", 64'(bus.m0_ack_o), 64'h0);
    step();
    bus.s_ack_i = 1'b1;
    #1;
    check("wr_m0_ack", 64'(bus.m0_ack_o), 64'h1);
    check("wr_m1_ack", 64'(bus.m1_ack_o), 64'h0);
    step();
    bus.s_ack_i = 1'b0; bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
    #1;
    check("wr_ack_one", 64'(bus.m0_ack_o), 64'h0);
    step();

    // Slave ack while idle must not reach either master
    bus.s_ack_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m1_stb_i = 1'b1;
    #1;
    check("idle_ack", {62'h0, bus.m1_ack_o, bus.m0_ack_o}, 64'h0);
    bus.s_ack_i = 1'b0;

    // Alternation; pointer favours master 1 after the core's release
    bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("alt_gnt%0d", i), 64'(bus.gnt_o), 64'(alt_exp[i]));
      if (alt_exp[i] == 2'b10) begin
        bus.m1_cyc_i = 1'b0; bus.s_ack_i = 1'b1;
        #1 check("alt_m1_ack", 64'(bus.m1_ack_o), 64'h1);
      end else if (alt_exp[i] == 2'b01) begin
        bus.m0_cyc_i = 1'b0; bus.s_ack_i = 1'b1;
        #1 check("alt_m0_ack", 64'(bus.m0_ack_o), 64'h1);
      end else begin
        bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1; bus.s_ack_i = 1'b0;
      end
      step();
    end
    check("no_hop_gnt", 64'(bus.gnt_o), 64'h0);
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m1_stb_i = 1'b0; bus.s_ack_i = 1'b0;
    step();

    // Burst lock: m0 holds cyc through 4 acks
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.s_ack_i = 1'b1;
      #1;
      check($sformatf("lock_gnt%0d", i), 64'(bus.gnt_o), 64'h1);
      check("lock_acks", {62'h0, bus.m1_ack_o, bus.m0_ack_o}, 64'h1);
      step();
    end
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.s_ack_i = 1'b0;
    #1 check("lock_drop_gnt", 64'(bus.gnt_o), 64'h1);
    step();
    check("lock_idle_gnt", 64'(bus.gnt_o), 64'h0);
    step();
    check("lock_m1_gnt", 64'(bus.gnt_o), 64'h2);

    // Watchdog: m1 stb with no ack, now on cycle 1 of stb
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("wd_pre%0d", c), {62'h0, bus.m1_err_o, bus.s_stb_o}, 64'h1);
      step();
    end
    check("wd_err", 64'(bus.m1_err_o), 64'h1);
    check("wd_m0_err", 64'(bus.m0_err_o), 64'h0);
    check("wd_stb_supp", 64'(bus.s_stb_o), 64'h0);
    check("wd_gnt", 64'(bus.gnt_o), 64'h2);
    step();
    check("wd_err_pulse", 64'(bus.m1_err_o), 64'h0);
    check("wd_stb_held", 64'(bus.s_stb_o), 64'h0);
    check("wd_gnt_held", 64'(bus.gnt_o), 64'h2);
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    step();
    check("wd_release", 64'(bus.gnt_o), 64'h0);

    // Ack on the threshold cycle wins over the watchdog
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
    step();
    repeat (15) step();
    bus.s_ack_i = 1'b1;
    #1;
    check("thr_ack", 64'(bus.m1_ack_o), 64'h1);
    check("thr_noerr", 64'(bus.m1_err_o), 64'h0);
    step();
    bus.s_ack_i = 1'b0;
    #1;
    check("thr_after_err", 64'(bus.m1_err_o), 64'h0);
    check("thr_after_stb", 64'(bus.s_stb_o), 64'h1);
    step();
    check("thr_after2_err", 64'(bus.m1_err_o), 64'h0);

    // Asynchronous reset mid-burst
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(bus.gnt_o), 64'h0);
    check("mid_rst_cyc", 64'(bus.s_cyc_o), 64'h0);
    check("mid_rst_stb", 64'(bus.s_stb_o), 64'h0);
    step();
    rst = 1'b0; bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    step();
    check("mid_rst_idle", 64'(bus.gnt_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
